arbitro_mult: RTL and testbench
===============================

ARBITRO_MULT -- requirements
Module: arbitro_mult

Interface
REQ-001 N_REQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 WIDTH, default 8, operand width in bits.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  N_REQ  per-requester request, level; held until matching gnt bit seen.
REQ-006 multiplicando  input  N_REQ*WIDTH  packed operands; slice i belongs to requester i.
REQ-007 multiplicador  input  N_REQ*WIDTH  packed operands; slice i belongs to requester i.
REQ-008 gnt  output  N_REQ  one-hot, one-cycle pulse: operands of requester i captured.
REQ-009 ocupado  output  1  high whenever state is not REPOUSO.
REQ-010 valido  output  1  one-cycle pulse: produto and id_resp valid.
REQ-011 id_resp  output  clog2(N_REQ)  index of requester owning produto.
REQ-012 produto  output  2*WIDTH  unsigned product of last completed job.

Function
REQ-013 FSM states SHALL be REPOUSO, CALCULA, FIM.
REQ-014 REPOUSO: at an edge with req nonzero, SHALL capture winner's operands, set cnt=WIDTH, acc=0, go to CALCULA, assert winner's gnt bit for exactly the following cycle.
REQ-015 REPOUSO with req==0 SHALL remain in REPOUSO; gnt stays 0.
REQ-016 Arbitration SHALL be round-robin: search starts at index ptr+1, wrapping modulo N_REQ; ptr updates to granted index on each grant.
REQ-017 CALCULA, each edge: if a[0] then acc=acc+b; a=a>>1; b=b<<1 (b is 2*WIDTH wide); cnt=cnt-1.
REQ-018 CALCULA SHALL go to FIM at the edge where cnt reaches 0 (exactly WIDTH CALCULA cycles).
REQ-019 FIM: produto=acc and id_resp=winner SHALL be driven with valido=1 for exactly one cycle; next edge goes to REPOUSO.
REQ-020 Latency: counting the grant-sampling edge as edge 1, valido SHALL be high in the cycle after edge WIDTH+1; throughput one job per WIDTH+2 cycles.
REQ-021 produto and id_resp SHALL hold their values until the next FIM; no overflow, since 2*WIDTH holds the full product.
REQ-022 req changes while ocupado=1 SHALL be ignored; captured operands SHALL NOT be affected by input changes after capture.
REQ-023 A requester still asserting req in the gnt cycle SHALL be treated as a new request and served only after any other pending requesters, per round-robin.

Reset
REQ-024 reset_n low at an edge SHALL force REPOUSO, gnt=0, valido=0, ocupado=0, produto=0, id_resp=0, ptr=N_REQ-1 (requester 0 wins first).
REQ-025 Reset during CALCULA or FIM SHALL abort the job with no valido pulse; reset has priority over all other events.

Configuration
REQ-026 Macro ARBITRO_MULT_FAST_ZERO_EN defined: CALCULA SHALL go to FIM at the first edge where the shifted a becomes 0 or cnt reaches 0 (minimum one CALCULA cycle); result identical.
REQ-027 Macro undefined: CALCULA SHALL always last exactly WIDTH cycles (fixed latency per REQ-020).

Structure
REQ-028 Package arbitro_mult_pkg SHALL hold the state enum typedef, default N_REQ/WIDTH constants and the index-width helper.
REQ-029 Shift-add datapath SHALL be sub-module mult_seq_nucleo (load, step, a_zero, acc); arbitro_mult holds FSM, arbiter, counter and outputs.

Verification (N_REQ=4, WIDTH=8)
REQ-030 reset_n low 2 cycles with req=1111 -> gnt=0, valido=0, ocupado=0, produto=0.
REQ-031 req=0001, slice0 13x11 -> gnt=0001 one cycle; valido after edge 9; produto=143, id_resp=0.
REQ-032 req=0100, slice2 255x255 -> produto=65025, id_resp=2.
REQ-033 req=1111 held through every grant -> grant order 0,1,2,3,0; each valido carries matching id_resp.
REQ-034 reset_n low during 4th CALCULA cycle -> no valido, produto=0, next grant goes to requester 0.
REQ-035 slice0 multiplicando=0, multiplicador=200 -> produto=0; valido after edge 3 with ARBITRO_MULT_FAST_ZERO_EN, after edge 9 without.

Source files
------------

// File: rtl/arbitro_mult_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_mult_pkg
// Shared definitions for the round-robin arbitrated sequential multiplier:
//   - default requester count and operand width
//   - controller state encoding
//   - index-width helper (at least one bit, even for a single requester)
// -----------------------------------------------------------------------------
package arbitro_mult_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      REPOUSO = 2'd0,
      CALCULA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arbitro_mult_nucleo.sv
// -----------------------------------------------------------------------------
// mult_seq_nucleo
// Shift-add datapath for one unsigned WIDTH x WIDTH multiplication.
//   clock    : rising-edge clock
//   reset_n  : synchronous active-low reset (clears all registers)
//   load     : capture a_in / b_in and clear the accumulator
//   step     : perform one shift-add iteration
//   a_in     : multiplicand (shifted right, its LSB selects the add)
//   b_in     : multiplier (zero-extended to 2*WIDTH, shifted left)
//   a_zero   : registered a is zero (only with ARBITRO_MULT_FAST_ZERO_EN)
//   acc      : accumulator value including the current iteration's add, so the
//              controller can latch the final product on the last step edge
// Optional feature macro: ARBITRO_MULT_FAST_ZERO_EN (exports a_zero).
// -----------------------------------------------------------------------------
module mult_seq_nucleo #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
`ifdef ARBITRO_MULT_FAST_ZERO_EN
   output logic               a_zero,
`endif
   output logic [2*WIDTH-1:0] acc
);

   logic [WIDTH-1:0]   a_q, a_d;
   logic [2*WIDTH-1:0] b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] acc_step;

   assign acc_step = a_q[0] ? (acc_q + b_q) : acc_q;
   assign acc      = acc_step;

`ifdef ARBITRO_MULT_FAST_ZERO_EN
   assign a_zero = (a_q == '0);
`endif

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (load) begin
         a_d   = a_in;
         b_d   = {{WIDTH{1'b0}}, b_in};
         acc_d = '0;
      end else if (step) begin
         a_d   = a_q >> 1;
         b_d   = b_q << 1;
         acc_d = acc_step;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/arbitro_mult.sv
// -----------------------------------------------------------------------------
// arbitro_mult
// N_REQ requesters share one sequential shift-add multiplier. A round-robin
// arbiter picks a requester while idle, its operands are captured, WIDTH
// shift-add steps run, and the product is presented with a one-cycle valid.
//   clock         : rising-edge clock
//   reset_n       : synchronous active-low reset
//   req           : per-requester level request
//   multiplicando : packed operands, slice i belongs to requester i
//   multiplicador : packed operands, slice i belongs to requester i
//   gnt           : one-hot, one-cycle pulse: requester's operands captured
//   ocupado       : controller not idle
//   valido        : one-cycle pulse, produto / id_resp valid
//   id_resp       : owner of produto
//   produto       : unsigned product of the last completed job (held)
// Optional feature macro: ARBITRO_MULT_FAST_ZERO_EN -- end the step phase
// early once the shifted multiplicand is already zero.
// -----------------------------------------------------------------------------
module arbitro_mult
   import arbitro_mult_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*WIDTH-1:0]      multiplicando,
   input  logic [N_REQ*WIDTH-1:0]      multiplicador,
   output logic [N_REQ-1:0]            gnt,
   output logic                        ocupado,
   output logic                        valido,
   output logic [idx_width(N_REQ)-1:0] id_resp,
   output logic [2*WIDTH-1:0]          produto
);

   localparam int IW = idx_width(N_REQ);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INI = CW'(WIDTH);
   localparam logic [IW-1:0] PTR_INI = IW'(N_REQ - 1);

   estado_t            state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      winner_q, winner_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               valido_q, valido_d;
   logic [IW-1:0]      id_resp_q, id_resp_d;
   logic [2*WIDTH-1:0] produto_q, produto_d;

   logic               load, step, calc_done;
   logic               arb_found;
   logic [IW-1:0]      arb_idx;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   a_arr [N_REQ];
   logic [WIDTH-1:0]   b_arr [N_REQ];
`ifdef ARBITRO_MULT_FAST_ZERO_EN
   logic               a_zero;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign a_arr[gi] = multiplicando[gi*WIDTH +: WIDTH];
         assign b_arr[gi] = multiplicador[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Round-robin: scan from the requester after the last winner, wrapping.
   always_comb begin
      int cand;
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(ptr_q) + k) % N_REQ;
         if (!arb_found && req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = IW'(cand);
         end
      end
   end

   mult_seq_nucleo #(
      .WIDTH (WIDTH)
   ) u_nucleo (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (load),
      .step    (step),
      .a_in    (a_arr[arb_idx]),
      .b_in    (b_arr[arb_idx]),
`ifdef ARBITRO_MULT_FAST_ZERO_EN
      .a_zero  (a_zero),
`endif
      .acc     (acc)
   );

   // The step phase ends on the edge that brings cnt to zero. With the fast
   // option it also ends once a (already shifted at least once) is zero; the
   // remaining steps would add nothing, so the result is unchanged.
`ifdef ARBITRO_MULT_FAST_ZERO_EN
   assign calc_done = (cnt_q == CW'(1)) || (a_zero && (cnt_q != CNT_INI));
`else
   assign calc_done = (cnt_q == CW'(1));
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      winner_d  = winner_q;
      cnt_d     = cnt_q;
      gnt_d     = '0;
      valido_d  = 1'b0;
      id_resp_d = id_resp_q;
      produto_d = produto_q;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         REPOUSO: begin
            if (arb_found) begin
               load           = 1'b1;
               winner_d       = arb_idx;
               ptr_d          = arb_idx;
               cnt_d          = CNT_INI;
               gnt_d[arb_idx] = 1'b1;
               state_d        = CALCULA;
            end
         end
         CALCULA: begin
            step  = 1'b1;
            cnt_d = cnt_q - CW'(1);
            if (calc_done) begin
               // acc already includes this edge's add: it is the final product.
               state_d   = FIM;
               valido_d  = 1'b1;
               produto_d = acc;
               id_resp_d = winner_q;
            end
         end
         FIM: begin
            state_d = REPOUSO;
         end
         default: begin
            state_d = REPOUSO;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= REPOUSO;
         ptr_q     <= PTR_INI;
         winner_q  <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         valido_q  <= 1'b0;
         id_resp_q <= '0;
         produto_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         winner_q  <= winner_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         valido_q  <= valido_d;
         id_resp_q <= id_resp_d;
         produto_q <= produto_d;
      end
   end

   assign gnt     = gnt_q;
   assign ocupado = (state_q != REPOUSO);
   assign valido  = valido_q;
   assign id_resp = id_resp_q;
   assign produto = produto_q;

endmodule

// File: tb/tb_arbitro_mult.sv
// -----------------------------------------------------------------------------
// tb_arbitro_mult
// Self-checking bench for arbitro_mult (N_REQ=4, WIDTH=8). A reference model
// (round-robin pick from the last winner, integer product, cycle count from the
// multiplicand's bit length) predicts each job. Honors
// ARBITRO_MULT_FAST_ZERO_EN in the latency model.
// -----------------------------------------------------------------------------
module tb_arbitro_mult;

   localparam int N = 4;
   localparam int W = 8;

   logic           clock = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] multiplicando;
   logic [N*W-1:0] multiplicador;
   logic [N-1:0]   gnt;
   logic           ocupado;
   logic           valido;
   logic [1:0]     id_resp;
   logic [2*W-1:0] produto;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int model_ptr = N - 1;

   arbitro_mult #(.N_REQ(N), .WIDTH(W)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req           (req),
      .multiplicando (multiplicando),
      .multiplicador (multiplicador),
      .gnt           (gnt),
      .ocupado       (ocupado),
      .valido        (valido),
      .id_resp       (id_resp),
      .produto       (produto)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Next winner: first requesting index after the previous winner, wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (p + k) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // Number of step cycles for multiplicand a.
   function automatic int calc_cycles(input logic [W-1:0] a);
      int len;
      len = 0;
      for (int i = 0; i < W; i++) if (a[i]) len = i + 1;
`ifdef ARBITRO_MULT_FAST_ZERO_EN
      if (len == 0) return 2;
      return (len + 1 < W) ? len + 1 : W;
`else
      return (len >= 0) ? W : 0;
`endif
   endfunction

   // Waits for one job and reports what it saw; callers compare.
   task automatic observe_job(input bit drop, input bit scramble,
                              output logic [N-1:0] g_vec, output logic [N-1:0] g_after,
                              output int gcyc, output int v_off, output logic v_after,
                              output logic [2*W-1:0] prod, output logic [1:0] id,
                              output bit timeout);
      int n;
      timeout = 1'b0; g_vec = '0; g_after = '0; gcyc = 0; v_off = -1;
      v_after = 1'b0; prod = '0; id = '0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (gnt == '0 && n < 40);
      if (gnt == '0) begin
         timeout = 1'b1;
         return;
      end
      g_vec = gnt;
      gcyc  = cyc;
      if (drop) req = req & ~gnt;
      if (scramble) begin
         multiplicando = $urandom;
         multiplicador = $urandom;
      end
      @(negedge clock);
      g_after = gnt;
      n = 0;
      while (valido !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (valido !== 1'b1) begin
         timeout = 1'b1;
         return;
      end
      v_off = cyc - gcyc;
      prod  = produto;
      id    = id_resp;
      @(negedge clock);
      v_after = valido;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      req = '1;
      multiplicando = $urandom;
      multiplicador = $urandom;
      repeat (2) @(negedge clock);
      checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b expected 0", valido); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
      checks++; if (produto !== '0) begin errors++; $display("FAIL reset_produto: got %0d expected 0", produto); end
      checks++; if (id_resp !== '0) begin errors++; $display("FAIL reset_id_resp: got %0d expected 0", id_resp); end
      req = '0;
      reset_n = 1'b1;
      model_ptr = N - 1;
      repeat (3) @(negedge clock);
      checks++; if (gnt !== '0 || ocupado !== 1'b0) begin
         errors++; $display("FAIL idle_no_req: got gnt=%b ocupado=%b expected gnt=0000 ocupado=0", gnt, ocupado);
      end
      $display("test_reset done");
   endtask

   // One job from a single requester with fixed operands.
   task automatic test_one(input string name, input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [N-1:0] g_vec, g_after, r;
      logic [2*W-1:0] prod, ep;
      logic [1:0] id;
      logic v_after;
      int gcyc, v_off, e;
      bit to;
      multiplicando = $urandom;
      multiplicador = $urandom;
      multiplicando[idx*W +: W] = a;
      multiplicador[idx*W +: W] = b;
      r = '0;
      r[idx] = 1'b1;
      req = r;
      e = rr_pick(r, model_ptr);
      ep = (2*W)'(a) * (2*W)'(b);
      observe_job(1'b1, 1'b0, g_vec, g_after, gcyc, v_off, v_after, prod, id, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL %s_timeout: got no gnt/valido expected job done", name);
      end else begin
         checks++; if (g_vec !== N'(1 << e)) begin errors++; $display("FAIL %s_gnt: got %b expected %b", name, g_vec, N'(1 << e)); end
         checks++; if (g_after !== '0) begin errors++; $display("FAIL %s_gnt_pulse: got %b expected 0000", name, g_after); end
         checks++; if (v_off !== calc_cycles(a)) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, v_off, calc_cycles(a)); end
         checks++; if (prod !== ep) begin errors++; $display("FAIL %s_produto: got %0d expected %0d", name, prod, ep); end
         checks++; if (id !== 2'(e)) begin errors++; $display("FAIL %s_id: got %0d expected %0d", name, id, e); end
         checks++; if (v_after !== 1'b0) begin errors++; $display("FAIL %s_valido_pulse: got %b expected 0", name, v_after); end
         checks++; if (ocupado !== 1'b0 || produto !== ep) begin
            errors++; $display("FAIL %s_hold: got ocupado=%b produto=%0d expected 0 %0d", name, ocupado, produto, ep);
         end
      end
      $display("%s: req=%b a=%0d b=%0d gnt=%b produto=%0d id=%0d latency=%0d", name, r, a, b, g_vec, prod, id, v_off);
      model_ptr = e;
      req = '0;
   endtask

   task automatic test_round_robin;
      logic [N-1:0] g_vec, g_after;
      logic [2*W-1:0] prod, ep;
      logic [1:0] id;
      logic v_after;
      logic [W-1:0] ea;
      int gcyc, prev_gcyc, prev_cycles, v_off, e;
      bit to;
      reset_n = 1'b0;
      req = '0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      model_ptr = N - 1;
      for (int i = 0; i < N; i++) begin
         multiplicando[i*W +: W] = W'($urandom_range(1, 255));
         multiplicador[i*W +: W] = W'($urandom_range(1, 255));
      end
      req = '1;
      prev_gcyc = 0;
      prev_cycles = 0;
      for (int j = 0; j < 5; j++) begin
         e  = rr_pick(req, model_ptr);
         ea = multiplicando[e*W +: W];
         ep = (2*W)'(ea) * (2*W)'(multiplicador[e*W +: W]);
         observe_job(1'b0, 1'b0, g_vec, g_after, gcyc, v_off, v_after, prod, id, to);
         checks++;
         if (to) begin
            errors++; $display("FAIL rr_timeout: got no gnt/valido expected job %0d", j);
            break;
         end
         checks++; if (g_vec !== N'(1 << e)) begin errors++; $display("FAIL rr_gnt: got %b expected %b", g_vec, N'(1 << e)); end
         checks++; if (id !== 2'(e)) begin errors++; $display("FAIL rr_id: got %0d expected %0d", id, e); end
         checks++; if (prod !== ep) begin errors++; $display("FAIL rr_produto: got %0d expected %0d", prod, ep); end
         if (j > 0) begin
            checks++;
            if (gcyc - prev_gcyc !== prev_cycles + 2) begin
               errors++; $display("FAIL rr_throughput: got %0d expected %0d", gcyc - prev_gcyc, prev_cycles + 2);
            end
         end
         $display("rr job %0d: gnt=%b id=%0d produto=%0d", j, g_vec, id, prod);
         prev_gcyc = gcyc;
         prev_cycles = calc_cycles(ea);
         model_ptr = e;
      end
      req = '0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid;
      logic [N-1:0] g_vec, g_after;
      logic [2*W-1:0] prod, ep;
      logic [1:0] id;
      logic v_after;
      int gcyc, v_off, e, n, n_val;
      bit to;
      multiplicando[0 +: W] = 8'd200;
      multiplicador[0 +: W] = 8'd3;
      req = 4'b0001;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (gnt == '0 && n < 40);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL abort_gnt: got %b expected 0001", gnt); end
      req = '0;
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      n_val = 0;
      repeat (2) begin
         @(negedge clock);
         if (valido === 1'b1) n_val++;
      end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL abort_ocupado: got %b expected 0", ocupado); end
      checks++; if (produto !== '0) begin errors++; $display("FAIL abort_produto: got %0d expected 0", produto); end
      checks++; if (id_resp !== '0) begin errors++; $display("FAIL abort_id_resp: got %0d expected 0", id_resp); end
      reset_n = 1'b1;
      model_ptr = N - 1;
      repeat (12) begin
         @(negedge clock);
         if (valido === 1'b1) n_val++;
      end
      checks++; if (n_val !== 0) begin errors++; $display("FAIL abort_no_valido: got %0d pulses expected 0", n_val); end
      multiplicando = $urandom;
      multiplicador = $urandom;
      req = '1;
      e  = rr_pick(req, model_ptr);
      ep = (2*W)'(multiplicando[e*W +: W]) * (2*W)'(multiplicador[e*W +: W]);
      observe_job(1'b1, 1'b0, g_vec, g_after, gcyc, v_off, v_after, prod, id, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL abort_next_timeout: got no job expected job");
      end else begin
         checks++; if (g_vec !== N'(1 << e)) begin errors++; $display("FAIL abort_next_gnt: got %b expected %b", g_vec, N'(1 << e)); end
         checks++; if (prod !== ep) begin errors++; $display("FAIL abort_next_produto: got %0d expected %0d", prod, ep); end
      end
      $display("reset_mid: pulses=%0d next gnt=%b produto=%0d", n_val, g_vec, prod);
      model_ptr = e;
      req = '0;
   endtask

   // Random request patterns, operands scrambled after capture.
   task automatic test_random;
      logic [N-1:0] g_vec, g_after, r;
      logic [2*W-1:0] prod, ep;
      logic [1:0] id;
      logic v_after;
      logic [W-1:0] ea;
      int gcyc, v_off, e;
      bit to;
      for (int j = 0; j < 20; j++) begin
         r = N'($urandom_range(1, (1 << N) - 1));
         multiplicando = $urandom;
         multiplicador = $urandom;
         if (j % 4 == 1) multiplicando = '0;
         if (j % 4 == 2) multiplicando = '1;
         req = r;
         e  = rr_pick(r, model_ptr);
         ea = multiplicando[e*W +: W];
         ep = (2*W)'(ea) * (2*W)'(multiplicador[e*W +: W]);
         observe_job(1'b1, 1'b1, g_vec, g_after, gcyc, v_off, v_after, prod, id, to);
         checks++;
         if (to) begin
            errors++; $display("FAIL rand_timeout: got no job expected job %0d", j);
            break;
         end
         checks++; if (g_vec !== N'(1 << e)) begin errors++; $display("FAIL rand_gnt: got %b expected %b", g_vec, N'(1 << e)); end
         checks++; if (g_after !== '0) begin errors++; $display("FAIL rand_gnt_pulse: got %b expected 0000", g_after); end
         checks++; if (v_off !== calc_cycles(ea)) begin errors++; $display("FAIL rand_latency: got %0d expected %0d", v_off, calc_cycles(ea)); end
         checks++; if (prod !== ep) begin errors++; $display("FAIL rand_produto: got %0d expected %0d", prod, ep); end
         checks++; if (id !== 2'(e)) begin errors++; $display("FAIL rand_id: got %0d expected %0d", id, e); end
         checks++; if (v_after !== 1'b0) begin errors++; $display("FAIL rand_valido_pulse: got %b expected 0", v_after); end
         $display("rand %0d: req=%b gnt=%b id=%0d produto=%0d latency=%0d", j, r, g_vec, id, prod, v_off);
         model_ptr = e;
         req = '0;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      req = '0;
      multiplicando = '0;
      multiplicador = '0;
      @(negedge clock);
      test_reset();
      test_one("single", 0, 8'd13, 8'd11);
      test_one("max", 2, 8'd255, 8'd255);
      test_one("zero", 0, 8'd0, 8'd200);
      test_round_robin();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
